// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit helpers for the BCD-to-binary converter.
package bcd_pkg;

    localparam int DIGIT_MAX   = 9;
    localparam int CORR_THRESH = 8;
    localparam int CORR_SUB    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    function automatic logic digit_valid(input logic [3:0] nibble);
        return (nibble <= 4'(DIGIT_MAX));
    endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 when the digit is 8 or more.
module bcd_digit_corr
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Per-digit correction, no borrow into neighbouring digits
    always_comb begin
        if (din >= 4'(CORR_THRESH)) begin
            dout = din - 4'(CORR_SUB);
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift per clock.
// A start pulse on en returns the binary value with a one-cycle rdy pulse BIN_W cycles later.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   bcd_d_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  rdy,
    output logic                  busy,
    output logic                  err
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    state_t            state_r, state_s;
    logic [BW-1:0]     bcd_r, bcd_s;
    logic [BIN_W-1:0]  bin_r, bin_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [BIN_W-1:0]  bin_out_r, bin_out_s;
    logic              err_r, err_s;
    logic              rdy_r, rdy_s;
    logic              busy_r, busy_s;

    logic [BW+BIN_W-1:0] cat_s;
    logic [BW-1:0]       bcd_shift_s;
    logic [BW-1:0]       bcd_corr_s;
    logic [BIN_W-1:0]    bin_shift_s;
    logic                bad_s;
    logic                accept_s;
    logic                last_s;

    // Joint right shift: the BCD LSB falls into the binary MSB
    always_comb begin
        cat_s       = {bcd_r, bin_r} >> 1;
        bcd_shift_s = cat_s[BW+BIN_W-1:BIN_W];
        bin_shift_s = cat_s[BIN_W-1:0];
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_corr
            bcd_digit_corr u_corr (
                .din  (bcd_shift_s[4*g +: 4]),
                .dout (bcd_corr_s[4*g +: 4])
            );
        end
    endgenerate

    // Flag any input digit above 9
    always_comb begin
        bad_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!digit_valid(bcd_d_in[4*i +: 4])) begin
                bad_s = 1'b1;
            end else begin
                bad_s = bad_s;
            end
        end
    end

    assign accept_s = en && ((state_r == IDLE) || (state_r == DONE));
    assign last_s   = (cnt_r == CW'(BIN_W - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_s = bad_s ? FAULT : SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            FAULT:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath and output next values; results are loaded only on completion
    always_comb begin
        bcd_s     = bcd_r;
        bin_s     = bin_r;
        cnt_s     = cnt_r;
        bin_out_s = bin_out_r;
        err_s     = err_r;
        rdy_s     = 1'b0;
        busy_s    = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    bcd_s  = bcd_d_in;
                    bin_s  = '0;
                    cnt_s  = '0;
                    busy_s = !bad_s;
                end else begin
                    busy_s = 1'b0;
                end
            end
            SHIFT: begin
                bcd_s = bcd_corr_s;
                bin_s = bin_shift_s;
                cnt_s = cnt_r + CW'(1);
                if (last_s) begin
                    bin_out_s = bin_shift_s;
                    err_s     = 1'b0;
                    rdy_s     = 1'b1;
                    busy_s    = 1'b0;
                end else begin
                    busy_s    = 1'b1;
                end
            end
            FAULT: begin
                bin_out_s = '0;
                err_s     = 1'b1;
                rdy_s     = 1'b1;
            end
            default: begin
                rdy_s = 1'b0;
            end
        endcase
    end

    // Working and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_r     <= '0;
            bin_r     <= '0;
            cnt_r     <= '0;
            bin_out_r <= '0;
            err_r     <= 1'b0;
            rdy_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            bcd_r     <= bcd_s;
            bin_r     <= bin_s;
            cnt_r     <= cnt_s;
            bin_out_r <= bin_out_s;
            err_r     <= err_s;
            rdy_r     <= rdy_s;
            busy_r    <= busy_s;
        end
    end

    assign bin_out = bin_out_r;
    assign err     = err_r;
    assign rdy     = rdy_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: arithmetic reference model plus directed vectors.
module tb_bcd_to_bin;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [15:0]       bcd_d_in;
    logic [BIN_W-1:0]  bin_out;
    logic              rdy;
    logic              busy;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .bcd_d_in (bcd_d_in),
        .bin_out  (bin_out),
        .rdy      (rdy),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal value of the digits, or error when any digit exceeds 9
    function automatic int ref_val(input logic [15:0] v);
        int acc;
        int w;
        logic [3:0] d;
        acc = 0;
        w   = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (d > 4'd9) return -1;
            acc = acc + int'(d) * w;
            w   = w * 10;
        end
        return acc;
    endfunction

    // Behavioural model: a conversion completes BIN_W edges after acceptance
    // (1 edge for an invalid input); new starts are accepted only when nothing is pending.
    int   m_left;
    int   m_pend;
    int   m_bin;
    logic m_err;
    logic m_rdy;
    logic m_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_pend <= 0;
            m_bin  <= 0;
            m_err  <= 1'b0;
            m_rdy  <= 1'b0;
            m_busy <= 1'b0;
        end else begin
            m_rdy <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_rdy  <= 1'b1;
                    m_busy <= 1'b0;
                    m_bin  <= (m_pend < 0) ? 0 : m_pend;
                    m_err  <= (m_pend < 0);
                end
            end else if (en) begin
                m_pend <= ref_val(bcd_d_in);
                if (ref_val(bcd_d_in) < 0) begin
                    m_left <= 1;
                    m_busy <= 1'b0;
                end else begin
                    m_left <= BIN_W;
                    m_busy <= 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_rdy",  int'(rdy),     int'(m_rdy));
            chk("cyc_busy", int'(busy),    int'(m_busy));
            chk("cyc_bin",  int'(bin_out), m_bin);
            chk("cyc_err",  int'(err),     int'(m_err));
        end
    end

    task automatic start(input logic [15:0] v);
        @(negedge clk);
        en       = 1'b1;
        bcd_d_in = v;
        @(negedge clk);
        en       = 1'b0;
        bcd_d_in = 16'hFFFF;
    endtask

    // Wait for rdy (bounded), then check latency and results against literals
    task automatic finish(input string name, input int exp_bin, input int exp_err,
                          input int exp_lat, input int k0);
        int k;
        k = k0;
        while (!rdy && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_lat"}, k, exp_lat);
        chk({name, "_bin"}, int'(bin_out), exp_bin);
        chk({name, "_err"}, int'(err), exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        bcd_d_in = 16'h0000;

        // Pin the reference model with hand-computed values
        chk("ref_9999", ref_val(16'h9999), 9999);
        chk("ref_1000", ref_val(16'h1000), 1000);
        chk("ref_0031", ref_val(16'h0031), 31);
        chk("ref_00A5", ref_val(16'h00A5), -1);

        repeat (3) @(negedge clk);
        chk("rst_bin",  int'(bin_out), 0);
        chk("rst_rdy",  int'(rdy),     0);
        chk("rst_busy", int'(busy),    0);
        chk("rst_err",  int'(err),     0);
        rst_n = 1'b1;

        start(16'h0031);
        chk("busy_0031", int'(busy), 1);
        finish("c0031", 31, 0, 14, 0);

        // Reset in the middle of a conversion
        start(16'h0031);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("amid_bin",  int'(bin_out), 0);
        chk("amid_rdy",  int'(rdy),     0);
        chk("amid_busy", int'(busy),    0);
        chk("amid_err",  int'(err),     0);
        @(negedge clk);
        rst_n = 1'b1;
        start(16'h0001);
        finish("c0001", 1, 0, 14, 0);

        start(16'h0016);
        finish("c0016", 16, 0, 14, 0);
        start(16'h0000);
        finish("c0000", 0, 0, 14, 0);
        start(16'h1000);
        finish("c1000", 1000, 0, 14, 0);

        // Invalid digit, then recovery
        start(16'h00A5);
        finish("c00A5", 0, 1, 1, 0);
        start(16'h0042);
        finish("c0042", 42, 0, 14, 0);

        // en during SHIFT must be ignored
        start(16'h0123);
        repeat (3) @(negedge clk);
        en       = 1'b1;
        bcd_d_in = 16'h0456;
        @(negedge clk);
        en       = 1'b0;
        finish("c0123", 123, 0, 14, 4);

        // Back-to-back: en held on the DONE cycle
        start(16'h9999);
        finish("c9999", 9999, 0, 14, 0);
        en       = 1'b1;
        bcd_d_in = 16'h0777;
        @(negedge clk);
        en       = 1'b0;
        bcd_d_in = 16'h0000;
        chk("b2b_rdy_low", int'(rdy), 0);
        chk("b2b_hold", int'(bin_out), 9999);
        finish("c0777", 777, 0, 14, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
